// File: rtl/run_arbiter_if.sv
// run_arbiter_if: run-control handshake, host port, core port and data-memory
// port of the run arbiter. The slave modport is the arbiter's view. The master
// modport is the view of the surrounding system (host, core and memory).
interface run_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int CW = 16
);
  // Four-phase run handshake and run status
  logic          req;
  logic          done;
  logic          busy;
  logic          timeout;
  logic [CW-1:0] cycles;

  // Host access port
  logic          host_valid;
  logic          host_wr_en;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ready;
  logic [DW-1:0] host_rdata;
  logic          host_rvalid;

  // Core port
  logic          core_rst;
  logic          core_done;
  logic          core_wr_en;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic [DW-1:0] core_rdata;

  // Data-memory port (asynchronous read, synchronous write)
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req, host_valid, host_wr_en, host_addr, host_wdata,
           core_done, core_wr_en, core_addr, core_wdata, mem_rdata,
    output done, busy, timeout, cycles, host_ready, host_rdata, host_rvalid,
           core_rst, core_rdata, mem_wr_en, mem_addr, mem_wdata
  );

  modport master (
    output req, host_valid, host_wr_en, host_addr, host_wdata,
           core_done, core_wr_en, core_addr, core_wdata, mem_rdata,
    input  done, busy, timeout, cycles, host_ready, host_rdata, host_rvalid,
           core_rst, core_rdata, mem_wr_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/run_arbiter.sv
// run_arbiter: run controller and data-memory arbiter for the single-cycle core.
// Outside a run, the host owns the data memory. During a run, the core owns the
// memory and is held out of reset while the block counts cycles.
// Optional feature macro RUN_TIMEOUT_EN: when it is defined, a run also ends
// after MAX_CYCLES RUN cycles and timeout is raised. When it is undefined, a run
// ends only on core_done and the cycle counter saturates.
module run_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int CW         = 16,
  parameter int MAX_CYCLES = 1000
) (
  input  logic         clk,
  input  logic         reset,
  run_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [CW-1:0] r_cycles;
  logic [CW-1:0] w_cyclesInc;
  logic          r_timeout;
  logic [DW-1:0] r_hostRdata;
  logic          r_hostRvalid;

  logic          w_limitHit;
  logic          w_run;
  logic          w_done;
  logic          w_busy;
  logic          w_coreRst;
  logic          w_hostReady;
  logic          w_hostRead;
  logic          w_memWrEn;
  logic [AW-1:0] w_memAddr;
  logic [DW-1:0] w_memWdata;

`ifdef RUN_TIMEOUT_EN
  // The run is cut off on the edge that would make the count reach MAX_CYCLES.
  localparam logic [CW-1:0] LP_LIMIT = CW'(MAX_CYCLES - 1);
  assign w_limitHit  = (r_cycles == LP_LIMIT);
  assign w_cyclesInc = r_cycles + CW'(1);
`else
  // With no cycle limit the run never ends on its own, so the count must saturate.
  assign w_limitHit  = 1'b0;
  assign w_cyclesInc = (&r_cycles) ? r_cycles : r_cycles + CW'(1);
`endif

  // The limit must be nonzero and must fit in the cycle counter.
  assert property (@(posedge clk) (MAX_CYCLES >= 1) && (MAX_CYCLES <= (1 << CW) - 1));

  // State register. The reset is synchronous and active-low.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state logic and state-decoded control outputs.
  always_comb begin
    w_nextState = r_state;
    w_run       = 1'b0;
    w_done      = 1'b0;
    w_busy      = 1'b0;
    w_coreRst   = 1'b1;
    w_hostReady = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_hostReady = 1'b1;
        if (bus.req) w_nextState = ST_START;
      end
      ST_START: begin
        w_busy      = 1'b1;
        w_nextState = ST_RUN;
      end
      ST_RUN: begin
        w_busy    = 1'b1;
        w_run     = 1'b1;
        w_coreRst = 1'b0;
        if (bus.core_done || w_limitHit) w_nextState = ST_FINISH;
      end
      ST_FINISH: begin
        w_done      = 1'b1;
        w_hostReady = 1'b1;
        if (!bus.req) w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Cycle counter: cleared in START, counts each RUN edge, and holds otherwise.
  always_ff @(posedge clk) begin
    if (!reset)                  r_cycles <= '0;
    else if (r_state == ST_START) r_cycles <= '0;
    else if (r_state == ST_RUN)   r_cycles <= w_cyclesInc;
  end

  // Timeout flag: cleared in START, and set only when the limit ends the run.
  // If core_done arrives on the same edge, the run counts as a normal finish.
  always_ff @(posedge clk) begin
    if (!reset)                   r_timeout <= 1'b0;
    else if (r_state == ST_START) r_timeout <= 1'b0;
    else if (r_state == ST_RUN && !bus.core_done && w_limitHit) r_timeout <= 1'b1;
  end

  assign w_hostRead = bus.host_valid & ~bus.host_wr_en & w_hostReady;

  // Host read path: capture the memory word on the accepting edge and strobe rvalid for one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hostRdata  <= '0;
      r_hostRvalid <= 1'b0;
    end else begin
      r_hostRvalid <= w_hostRead;
      if (w_hostRead) r_hostRdata <= bus.mem_rdata;
    end
  end

  // Memory ownership mux: the core drives memory only in RUN. Otherwise the host drives it.
  always_comb begin
    w_memAddr  = bus.host_addr;
    w_memWdata = bus.host_wdata;
    w_memWrEn  = bus.host_valid & bus.host_wr_en & w_hostReady;
    if (w_run) begin
      w_memAddr  = bus.core_addr;
      w_memWdata = bus.core_wdata;
      w_memWrEn  = bus.core_wr_en;
    end
  end

  assign bus.done        = w_done;
  assign bus.busy        = w_busy;
  assign bus.timeout     = r_timeout;
  assign bus.cycles      = r_cycles;
  assign bus.host_ready  = w_hostReady;
  assign bus.host_rdata  = r_hostRdata;
  assign bus.host_rvalid = r_hostRvalid;
  assign bus.core_rst    = w_coreRst;
  assign bus.core_rdata  = bus.mem_rdata;
  assign bus.mem_wr_en   = w_memWrEn;
  assign bus.mem_addr    = w_memAddr;
  assign bus.mem_wdata   = w_memWdata;

endmodule

// File: doc/run_arbiter.md
# run_arbiter

Run controller and data-memory arbiter for the single-cycle processor. Outside a run, the host owns the data memory to preload operands and jump-table words (addresses 1–4). While the program runs, the block hands the memory to the core, releases the core's reset, and counts cycles until the core signals done or a timeout expires. It then returns memory ownership to the host for readback and completes a four-phase req/done handshake.

## Interface
Parameters:
- AW, 8, data-memory address width
- DW, 8, data-memory word width
- CW, 16, cycle-counter width
- MAX_CYCLES, 1000, RUN-cycle limit before timeout; must satisfy 1 ≤ MAX_CYCLES ≤ 2^CW−1

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- req  in  1  host start request, four-phase
- done  out  1  run complete, held until req falls
- busy  out  1  high in START and RUN
- timeout  out  1  last run ended by cycle limit
- cycles  out  CW  RUN cycles of last/current run
- host_valid  in  1  host access request
- host_wr_en  in  1  1 = write, 0 = read
- host_addr  in  AW  host address
- host_wdata  in  DW  host write data
- host_ready  out  1  host may access memory (combinational from state)
- host_rdata  out  DW  registered read data
- host_rvalid  out  1  one-cycle read-data strobe
- core_rst  out  1  active-high reset to the core
- core_done  in  1  core finished (PC reached end)
- core_wr_en  in  1  core store enable
- core_addr  in  AW  core memory address
- core_wdata  in  DW  core store data
- core_rdata  out  DW  memory read data to the core
- mem_wr_en  out  1  to data memory
- mem_addr  out  AW  to data memory
- mem_wdata  out  DW  to data memory
- mem_rdata  in  DW  from data memory (asynchronous read)

## Operation
- **State machine:** IDLE, START, RUN, FINISH.
- **IDLE:**
  - Host owns memory; core_rst=1.
  - req=1 → START.
- **START:**
  - One cycle. cycles cleared to 0, timeout cleared.
  - core_rst=1 (the core sees a clean reset edge).
  - → RUN.
- **RUN:**
  - Core owns memory; core_rst=0.
  - On each edge, cycles increments.
  - core_done=1 → FINISH.
  - Otherwise, if cycles==MAX_CYCLES−1 → FINISH with timeout=1.
- **FINISH:**
  - done=1, core_rst=1, host owns memory.
  - req=0 → IDLE; done drops on that same edge.
- **Memory mux** (combinational):
  - In RUN, mem_* = core_*.
  - Otherwise mem_addr=host_addr, mem_wdata=host_wdata, mem_wr_en = host_valid & host_wr_en & host_ready.
  - Core writes outside RUN are discarded.
- **Host port:**
  - host_ready=1 in IDLE and FINISH, 0 in START and RUN.
  - A write commits on the accepting edge.
  - An accepted read latches mem_rdata into host_rdata; host_rvalid=1 for exactly the next cycle.
  - host_valid while host_ready=0 is ignored; no queuing.
- **core_rdata** = mem_rdata at all times.
- **Simultaneous events:**
  - core_done on the limit cycle: done wins, timeout=0.
  - req falling during START or RUN is ignored; the run completes and FINISH exits immediately if req is already 0.
  - core_done outside RUN is ignored.
- **Counter:**
  - Wraps are impossible given the MAX_CYCLES bound.
  - cycles holds its value in FINISH and IDLE until the next START.

## Timing
- **Reset values:**
  - State IDLE.
  - done=0, busy=0, timeout=0, cycles=0.
  - host_rdata=0, host_rvalid=0.
  - core_rst=1.
  - host_ready=1, so the host may access memory in the first cycle after reset.
- **Reset mid-operation:** reset=0 in any state forces all of the above on the next edge. An in-flight host read's rvalid is suppressed.
- **Start latency:** req sampled high at edge N → START after N, RUN after N+1. The core's first un-reset cycle follows edge N+1.
- **Cycle count:** if core_done is first sampled at the k-th edge in RUN, FINISH is entered on that edge with cycles=k and done=1. Minimum k=1.
- **Timeout:** FINISH after exactly MAX_CYCLES RUN edges, with cycles=MAX_CYCLES.
- **Read latency:** one cycle from accept to host_rvalid.

## Configuration
- **RUN_TIMEOUT_EN defined:** cycle limit active as described.
- **RUN_TIMEOUT_EN undefined:**
  - RUN exits only on core_done.
  - timeout tied 0.
  - cycles still counts but saturates at 2^CW−1 instead of terminating the run.

## Test plan
- **Reset:** hold reset=0 three cycles with req=1 → state IDLE, core_rst=1, done=0, cycles=0, host_ready=1.
- **Preload and readback:**
  - Host writes 0x11/0x22/0x33/0x44 to addresses 1–4.
  - Host reads address 3 → host_rvalid pulses one cycle later with host_rdata=0x33.
  - No write occurs on the read cycle.
- **Normal run:**
  - req=1; core_done asserted on the 50th RUN cycle → done=1, cycles=50, timeout=0.
  - busy high for 51 cycles.
  - req=0 → done=0 next edge, state IDLE.
- **Timeout (RUN_TIMEOUT_EN, MAX_CYCLES=8):**
  - core_done held 0 → FINISH after 8 RUN cycles, cycles=8, timeout=1, core_rst=1.
  - Repeat with core_done rising on cycle 8 → timeout=0.
- **Ownership:**
  - During RUN, host_valid=1 write to address 5 → host_ready=0, memory unchanged.
  - Core store 0x7F to address 5 → mem_wr_en=1, memory holds 0x7F.
  - core_wr_en=1 in IDLE → mem_wr_en=0.
- **Reset mid-run:** reset=0 on RUN cycle 10 → next edge IDLE, core_rst=1, cycles=0, done=0; a new req runs normally.
